// File: rtl/uart_fifo_param.sv
// Parametrised synchronous FIFO for the UART TX/RX byte paths.
// Arbitrary depth, programmable almost-full/almost-empty thresholds, sticky error flags, show-ahead read.
module uart_fifo_param #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_LEVEL  = DEPTH - 2,
    parameter int AEMPTY_LEVEL = 1,
    localparam int PTR_W       = $clog2(DEPTH),
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstnn,
    input  logic             clear,
    input  logic             clear_flags,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_LEVEL);
    localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push_acc;
    logic             pop_acc;

    // Explicit wrap compare so non-power-of-2 depths roll over at DEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign push_acc = !clear && push && (!full || pop);
    assign pop_acc  = !clear && pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (push_acc) wptr_d = ptr_inc(wptr_q);
            if (pop_acc)  rptr_d = ptr_inc(rptr_q);
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // A new event outranks a coincident clear_flags.
            ovf_d = (push && full && !pop) || (ovf_q && !clear_flags);
            unf_d = (pop && empty) || (unf_q && !clear_flags);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstnn && push_acc) mem_q[wptr_q] <= wdata;
    end

    assign rdata        = mem_q[rptr_q];
    assign count        = count_q;
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_CNT);
    assign almost_empty = (count_q <= AEMPTY_CNT);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Self-checking bench for uart_fifo_param: a DEPTH=16 instance driven against a queue model,
// plus a DEPTH=5 instance for non-power-of-2 pointer wrap.
module tb_uart_fifo_param;

    logic clk;
    logic rstnn;

    logic       clear16, clear_flags16, push16, pop16;
    logic [7:0] wdata16, rdata16;
    logic [4:0] count16;
    logic       full16, empty16, afull16, aempty16, ovf16, unf16;

    logic       clear5, clear_flags5, push5, pop5;
    logic [7:0] wdata5, rdata5;
    logic [2:0] count5;
    logic       full5, empty5, afull5, aempty5, ovf5, unf5;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q16[$];
    logic [7:0] q5[$];
    logic       m_ovf, m_unf;

    uart_fifo_param #(.WIDTH(8), .DEPTH(16), .AFULL_LEVEL(14), .AEMPTY_LEVEL(1)) u_dut16 (
        .clk(clk), .rstnn(rstnn), .clear(clear16), .clear_flags(clear_flags16),
        .push(push16), .wdata(wdata16), .pop(pop16), .rdata(rdata16), .count(count16),
        .full(full16), .empty(empty16), .almost_full(afull16), .almost_empty(aempty16),
        .overflow(ovf16), .underflow(unf16)
    );

    uart_fifo_param #(.WIDTH(8), .DEPTH(5)) u_dut5 (
        .clk(clk), .rstnn(rstnn), .clear(clear5), .clear_flags(clear_flags5),
        .push(push5), .wdata(wdata5), .pop(pop5), .rdata(rdata5), .count(count5),
        .full(full5), .empty(empty5), .almost_full(afull5), .almost_empty(aempty5),
        .overflow(ovf5), .underflow(unf5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state16();
        int n;
        n = q16.size();
        check_val("count16", 32'(count16), 32'(n));
        check_val("full16", 32'(full16), 32'(n == 16));
        check_val("empty16", 32'(empty16), 32'(n == 0));
        check_val("almost_full16", 32'(afull16), 32'(n >= 14));
        check_val("almost_empty16", 32'(aempty16), 32'(n <= 1));
        check_val("overflow16", 32'(ovf16), 32'(m_ovf));
        check_val("underflow16", 32'(unf16), 32'(m_unf));
        if (n > 0) check_val("head16", 32'(rdata16), 32'(q16[0]));
    endtask

    // One clock of stimulus on the 16-deep FIFO; model updated alongside.
    task automatic cyc16(input logic pu, input logic [7:0] d, input logic po,
                         input logic clr, input logic clf);
        logic full_m, empty_m, pa, oa, ovf_ev, unf_ev;
        push16 = pu; wdata16 = d; pop16 = po; clear16 = clr; clear_flags16 = clf;
        full_m  = (q16.size() == 16);
        empty_m = (q16.size() == 0);
        if (clr) begin
            q16.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            pa     = pu && (!full_m || po);
            oa     = po && !empty_m;
            ovf_ev = pu && full_m && !po;
            unf_ev = po && empty_m;
            if (oa) check_val("rdata_pop16", 32'(rdata16), 32'(q16.pop_front()));
            if (pa) q16.push_back(d);
            m_ovf = ovf_ev || (m_ovf && !clf);
            m_unf = unf_ev || (m_unf && !clf);
        end
        @(posedge clk); #1;
        push16 = 1'b0; pop16 = 1'b0; clear16 = 1'b0; clear_flags16 = 1'b0;
        check_state16();
    endtask

    task automatic cyc5(input logic pu, input logic [7:0] d, input logic po);
        logic full_m, empty_m;
        push5 = pu; wdata5 = d; pop5 = po;
        full_m  = (q5.size() == 5);
        empty_m = (q5.size() == 0);
        if (po && !empty_m) check_val("rdata_pop5", 32'(rdata5), 32'(q5.pop_front()));
        if (pu && (!full_m || po)) q5.push_back(d);
        @(posedge clk); #1;
        push5 = 1'b0; pop5 = 1'b0;
        check_val("count5", 32'(count5), 32'(q5.size()));
    endtask

    task automatic do_reset();
        rstnn = 1'b0;
        @(posedge clk); #1;
        rstnn = 1'b1;
        q16.delete();
        q5.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_state16();
    endtask

    initial begin
        rstnn = 1'b0;
        clear16 = 0; clear_flags16 = 0; push16 = 0; pop16 = 0; wdata16 = '0;
        clear5 = 0; clear_flags5 = 0; push5 = 0; pop5 = 0; wdata5 = '0;
        m_ovf = 0; m_unf = 0;
        @(posedge clk); #1;
        do_reset();
        check_val("rst_empty", 32'(empty16), 32'd1);
        check_val("rst_aempty", 32'(aempty16), 32'd1);
        check_val("rst_count5", 32'(count5), 32'd0);

        // Fill, overflow, drain, underflow
        for (int i = 0; i < 16; i++) cyc16(1, 8'(i), 0, 0, 0);
        cyc16(1, 8'hAA, 0, 0, 0);
        check_val("t1_full", 32'(full16), 32'd1);
        check_val("t1_count", 32'(count16), 32'd16);
        check_val("t1_ovf", 32'(ovf16), 32'd1);
        for (int i = 0; i < 16; i++) cyc16(0, 8'h00, 1, 0, 0);
        check_val("t1_empty", 32'(empty16), 32'd1);
        cyc16(0, 8'h00, 1, 0, 0);
        check_val("t1_unf", 32'(unf16), 32'd1);

        // Non-power-of-2 wrap on DEPTH=5
        cyc5(1, 8'd1, 0);
        cyc5(1, 8'd2, 0);
        for (int d = 3; d <= 12; d++) cyc5(1, 8'(d), 1);
        cyc5(0, 8'd0, 1);
        cyc5(0, 8'd0, 1);
        check_val("t2_empty5", 32'(empty5), 32'd1);
        for (int i = 0; i < 5; i++) cyc5(1, 8'(8'h40 + i), 0);
        check_val("t2_full5", 32'(full5), 32'd1);
        cyc5(1, 8'h99, 1);
        check_val("t2_ovf5", 32'(ovf5), 32'd0);

        // Simultaneous push/pop when full and when empty
        cyc16(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 16; i++) cyc16(1, 8'(8'h80 + i), 0, 0, 0);
        cyc16(1, 8'hE1, 1, 0, 0);
        check_val("t3_full_cnt", 32'(count16), 32'd16);
        check_val("t3_full_ovf", 32'(ovf16), 32'd0);
        check_val("t3_head", 32'(rdata16), 32'h81);
        cyc16(0, 8'h00, 0, 1, 0);
        cyc16(1, 8'h5C, 1, 0, 0);
        check_val("t3_empty_cnt", 32'(count16), 32'd1);
        check_val("t3_empty_unf", 32'(unf16), 32'd1);
        check_val("t3_rdata", 32'(rdata16), 32'h5C);

        // Thresholds stepping 0..16
        cyc16(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 16; i++) cyc16(1, 8'($urandom_range(0, 255)), 0, 0, 0);
        check_val("t4_af16", 32'(afull16), 32'd1);
        for (int i = 0; i < 16; i++) cyc16(0, 8'h00, 1, 0, 0);

        // Clear and clear_flags
        cyc16(0, 8'h00, 0, 1, 0);
        cyc16(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 17; i++) cyc16(1, 8'(8'h20 + i), 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc16(0, 8'h00, 1, 0, 0);
        check_val("t5_count7", 32'(count16), 32'd7);
        check_val("t5_ovf_set", 32'(ovf16), 32'd1);
        check_val("t5_unf_set", 32'(unf16), 32'd1);
        cyc16(0, 8'h00, 0, 0, 1);
        check_val("t5_ovf_clr", 32'(ovf16), 32'd0);
        check_val("t5_unf_clr", 32'(unf16), 32'd0);
        check_val("t5_count_kept", 32'(count16), 32'd7);
        cyc16(1, 8'h77, 0, 1, 0);
        check_val("t5_clr_count", 32'(count16), 32'd0);
        check_val("t5_clr_empty", 32'(empty16), 32'd1);
        cyc16(0, 8'h00, 1, 0, 1);
        check_val("t5_new_event_wins", 32'(unf16), 32'd1);

        // Reset mid-operation
        cyc16(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 17; i++) cyc16(1, 8'(8'h60 + i), 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc16(0, 8'h00, 1, 0, 0);
        check_val("t6_count9", 32'(count16), 32'd9);
        check_val("t6_ovf", 32'(ovf16), 32'd1);
        do_reset();
        check_val("t6_rst_count", 32'(count16), 32'd0);
        check_val("t6_rst_ovf", 32'(ovf16), 32'd0);
        cyc16(1, 8'h3C, 0, 0, 0);
        check_val("t6_rdata", 32'(rdata16), 32'h3C);
        check_val("t6_count1", 32'(count16), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
